// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller for a DEPTH-word instruction memory.
// Owns the PC and delivers fetched words to decode over valid/ready.
// The memory port is shared with a program loader whenever the core is not running.
// Optional feature macro: FETCH_CNT_EN adds a saturating fetch_count output.
module imem_fetch_ctrl #(
    parameter int unsigned        DEPTH    = 64,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic              running,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
`ifdef FETCH_CNT_EN
    output logic [31:0]       fetch_count,
`endif
    output logic              ld_err
);

    // First byte address past the end of the memory.
    localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(4 * DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              fault_q, fault_d;
    logic              ld_err_q, ld_err_d;

    logic              ld_fire;
    logic              ld_in_range;
    logic              advance;

    // Memory port mux and loader handshake.
    always_comb begin
        running     = (state_q == StRun);
        ld_ready    = !running;
        ld_fire     = ld_valid && ld_ready;
        ld_in_range = (ld_addr < MemBytes);
        mem_wdata   = ld_data;
        mem_addr    = running ? pc_q : {ld_addr[ADDR_W-1:2], 2'b00};
        // A write is suppressed in the reset cycle.
        mem_we      = ld_fire && ld_in_range && !reset;
        ld_err_d    = ld_fire && !ld_in_range;
        advance     = !out_valid_q || out_ready;
    end

    // Next-state logic for the fetch FSM and output register.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fault_d     = fault_q;
        unique case (state_q)
            StIdle, StFault: begin
                if (start) begin
                    state_d     = StRun;
                    pc_d        = RESET_PC;
                    fault_d     = 1'b0;
                    out_valid_d = 1'b0;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    pc_d        = {redirect_pc[ADDR_W-1:2], 2'b00};
                    if (halt) begin
                        state_d = StIdle;
                    end
                end else if (halt) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (advance) begin
                    // Also catches PC wrap-around past the top of the address space.
                    if (pc_q >= MemBytes) begin
                        state_d     = StFault;
                        fault_d     = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        out_instr_d = mem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + ADDR_W'(4);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            fault_q     <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            fault_q     <= fault_d;
            ld_err_q    <= ld_err_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count_q;

    // Saturating count of accepted instructions, cleared on reset and start.
    always_ff @(posedge clk) begin
        if (reset || (start && !running)) begin
            fetch_count_q <= '0;
        end else if (out_valid_q && out_ready && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign fault     = fault_q;
    assign ld_err    = ld_err_q;

endmodule
